// File: rtl/mux_stream_arb_pkg.sv
// Shared types and constants for the two-source stream arbiter.
package mux_stream_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

  localparam int          BURST_CNT_W = 4;
  localparam logic [15:0] STAT_MAX    = 16'hFFFF;

  function automatic arb_state_t own_state(input src_t src);
    return (src == SRC_B) ? OWN_B : OWN_A;
  endfunction

endpackage

// File: rtl/mux_stream_arb_grant.sv
// Combinational round-robin grant with bounded bursts; no state of its own.
module mux_stream_arb_grant
  import mux_stream_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  arb_state_t             state_i,
  input  logic [BURST_CNT_W-1:0] burst_cnt_i,
  input  src_t                   last_owner_i,
  input  logic                   a_valid_i,
  input  logic                   b_valid_i,
  output src_t                   grant_o,
  output logic                   grant_vld_o
);

  localparam logic [BURST_CNT_W-1:0] MAX_CNT = BURST_CNT_W'(MAX_BURST);

  src_t own_s;
  logic own_vld_s;
  logic oth_vld_s;

  // Owner keeps the grant until its burst is used up and the other side waits.
  always_comb begin
    grant_o     = SRC_A;
    grant_vld_o = 1'b0;
    own_s       = (state_i == OWN_B) ? SRC_B : SRC_A;
    own_vld_s   = (own_s == SRC_B) ? b_valid_i : a_valid_i;
    oth_vld_s   = (own_s == SRC_B) ? a_valid_i : b_valid_i;
    case (state_i)
      OWN_A, OWN_B: begin
        if (own_vld_s && (!oth_vld_s || (burst_cnt_i < MAX_CNT))) begin
          grant_o     = own_s;
          grant_vld_o = 1'b1;
        end else if (oth_vld_s) begin
          grant_o     = src_t'(~own_s);
          grant_vld_o = 1'b1;
        end else begin
          grant_vld_o = 1'b0;
        end
      end
      default: begin
        if (a_valid_i && b_valid_i) begin
          grant_o     = src_t'(~last_owner_i);
          grant_vld_o = 1'b1;
        end else if (a_valid_i) begin
          grant_o     = SRC_A;
          grant_vld_o = 1'b1;
        end else if (b_valid_i) begin
          grant_o     = SRC_B;
          grant_vld_o = 1'b1;
        end else begin
          grant_vld_o = 1'b0;
        end
      end
    endcase
  end

endmodule

// File: rtl/mux_stream_arb.sv
// Two-source valid/ready arbiter driving a 2:1 byte mux into a single output register.
// Optional per-source transfer counters under MUX_STREAM_ARB_STATS_EN.
module mux_stream_arb
  import mux_stream_arb_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid_i,
  input  logic [DATA_W-1:0] a_data_i,
  output logic              a_ready_o,
  input  logic              b_valid_i,
  input  logic [DATA_W-1:0] b_data_i,
  output logic              b_ready_o,
  output logic              sel_o,
  output logic              y_valid_o,
  output logic [DATA_W-1:0] y_data_o,
  input  logic              y_ready_i
`ifdef MUX_STREAM_ARB_STATS_EN
  ,
  input  logic              stats_clr_i,
  output logic [15:0]       a_cnt_o,
  output logic [15:0]       b_cnt_o
`endif
);

  localparam logic [BURST_CNT_W-1:0] MAX_CNT = BURST_CNT_W'(MAX_BURST);

  arb_state_t             state_q, state_d;
  logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  src_t                   last_owner_q, last_owner_d;
  logic                   sel_q, sel_d;
  logic                   y_valid_q, y_valid_d;
  logic [DATA_W-1:0]      y_data_q, y_data_d;

  src_t              grant_s;
  logic              grant_vld_s;
  logic              load_en_s;
  logic              xfer_s;
  logic [DATA_W-1:0] mux_data_s;

  mux_stream_arb_grant #(.MAX_BURST(MAX_BURST)) u_grant (
    .state_i      (state_q),
    .burst_cnt_i  (burst_cnt_q),
    .last_owner_i (last_owner_q),
    .a_valid_i    (a_valid_i),
    .b_valid_i    (b_valid_i),
    .grant_o      (grant_s),
    .grant_vld_o  (grant_vld_s)
  );

  // Handshake outputs are gated by reset so they read 0 while it is held.
  always_comb begin
    load_en_s  = !y_valid_q || y_ready_i;
    mux_data_s = (grant_s == SRC_B) ? b_data_i : a_data_i;
    a_ready_o  = reset && load_en_s && grant_vld_s && (grant_s == SRC_A) && a_valid_i;
    b_ready_o  = reset && load_en_s && grant_vld_s && (grant_s == SRC_B) && b_valid_i;
    xfer_s     = a_ready_o || b_ready_o;
    sel_o      = reset && (grant_vld_s ? (grant_s == SRC_B) : sel_q);
    y_valid_o  = y_valid_q;
    y_data_o   = y_data_q;
  end

  // Next-state for arbitration state and the output stage.
  always_comb begin
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    last_owner_d = last_owner_q;
    y_valid_d    = y_valid_q;
    y_data_d     = y_data_q;
    sel_d        = grant_vld_s ? (grant_s == SRC_B) : sel_q;
    if (xfer_s) begin
      y_data_d  = mux_data_s;
      y_valid_d = 1'b1;
      if (state_q == own_state(grant_s)) begin
        burst_cnt_d = (burst_cnt_q >= MAX_CNT) ? MAX_CNT : burst_cnt_q + BURST_CNT_W'(1);
      end else begin
        burst_cnt_d  = BURST_CNT_W'(1);
        state_d      = own_state(grant_s);
        last_owner_d = grant_s;
      end
    end else begin
      if (y_ready_i && y_valid_q) begin
        y_valid_d = 1'b0;
      end else begin
        y_valid_d = y_valid_q;
      end
      if (load_en_s && !a_valid_i && !b_valid_i) begin
        state_d     = IDLE;
        burst_cnt_d = '0;
      end else begin
        state_d     = state_q;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      burst_cnt_q  <= '0;
      last_owner_q <= SRC_B;
      sel_q        <= 1'b0;
      y_valid_q    <= 1'b0;
      y_data_q     <= '0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      last_owner_q <= last_owner_d;
      sel_q        <= sel_d;
      y_valid_q    <= y_valid_d;
      y_data_q     <= y_data_d;
    end
  end

`ifdef MUX_STREAM_ARB_STATS_EN
  logic [15:0] a_cnt_q, a_cnt_d;
  logic [15:0] b_cnt_q, b_cnt_d;

  // Saturating counters; a clear wins over a same-cycle increment.
  always_comb begin
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    if (stats_clr_i) begin
      a_cnt_d = 16'd0;
      b_cnt_d = 16'd0;
    end else begin
      if (a_ready_o && (a_cnt_q != STAT_MAX)) a_cnt_d = a_cnt_q + 16'd1;
      else                                    a_cnt_d = a_cnt_q;
      if (b_ready_o && (b_cnt_q != STAT_MAX)) b_cnt_d = b_cnt_q + 16'd1;
      else                                    b_cnt_d = b_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_cnt_q <= 16'd0;
      b_cnt_q <= 16'd0;
    end else begin
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
    end
  end

  assign a_cnt_o = a_cnt_q;
  assign b_cnt_o = b_cnt_q;
`endif

endmodule
